s2_fmap_buffer: RTL and testbench
=================================

Name: s2_fmap_buffer

Overview:
- Downstream stage of the C1S2 layer. Captures the layer's single-port write stream (14x14x6 pooled feature maps) into on-chip storage.
- Once the layer reports completion, it exposes the stored maps to the next layer (C3S4) through five parallel read ports with BRAM-style 1-cycle latency.
- A three-state ownership FSM sequences producer and consumer. Each side is given the buffer only when the other has finished with it.

Parameters:
- DATA_W, 16, feature-map word width
- DEPTH, 1176, stored words (6 maps x 14 x 14)
- ADDR_W, 11, internal memory address width; must satisfy 2**ADDR_W >= DEPTH
- NPORT, 5, number of parallel read ports

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- up_en  in  1  producer (C1S2) layer enable, level
- up_fin  in  1  producer work_finished, level or pulse; rising edge used
- wr_addr_in  in  32  producer write address
- wr_data_in  in  DATA_W  producer write data
- wr_in_en  in  1  producer write strobe
- rd_addr_in_5P  in  32*NPORT  consumer read addresses; port p is in bits [32p+31:32p]
- rd_data_out_5P  out  DATA_W*NPORT  read data; port p is in bits [DATA_W*p+DATA_W-1:DATA_W*p]
- dn_en  out  1  consumer layer enable; high while the buffer is READY
- dn_fin  in  1  consumer work_finished; rising edge used
- buf_state  out  2  FSM state: 0 IDLE, 1 FILL, 2 READY
- wr_cnt  out  16  number of accepted writes since the last FILL entry; saturates at 16'hFFFF
- err_flag  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, dn_en=0, wr_cnt=0, err_flag=0, rd_data_out_5P=0.
  - Edge-detect registers for up_fin and dn_fin are set to 0.
  - Memory contents are not cleared.
  - Reset mid-FILL or mid-READY aborts immediately; the next operation starts from IDLE.
- Edge detection: up_fin_rise = up_fin & ~up_fin_q, with one register stage; dn_fin_rise is formed the same way.
- FSM:
  - IDLE -> FILL when up_en=1. On entry, wr_cnt and err_flag clear.
  - FILL -> READY on up_fin_rise.
  - READY -> IDLE on dn_fin_rise.
  - up_fin_rise outside FILL is ignored. dn_fin_rise outside READY is ignored.
- Write path:
  - A write is accepted when state==FILL, wr_in_en=1 and wr_addr_in < DEPTH (compare on the full 32 bits).
  - An accepted write stores wr_data_in into all NPORT memory copies at wr_addr_in[ADDR_W-1:0] and increments wr_cnt.
  - If wr_in_en=1 and the address is >= DEPTH, or the state is not FILL: the write is dropped and err_flag is set.
  - A write in the same cycle as up_fin_rise is accepted, because the state is still FILL in that cycle.
  - Duplicate addresses are allowed: last write wins, and both writes count in wr_cnt.
- Read path, each port independent:
  - Address sampled in cycle N; data is valid in cycle N+1.
  - Data is the memory word if, in cycle N, state==READY and the address < DEPTH. Otherwise the output is 0.
  - A read of an address that was never written returns stale memory content; this is not an error.
- dn_en:
  - Registered output, equal to (state==READY).
  - Rises 1 cycle after the up_fin rising edge is registered.
  - Falls in the cycle after dn_fin_rise.
- Simultaneous events:
  - up_en and dn_fin_rise in the same READY cycle: go to IDLE. Re-entry to FILL happens on the following cycle if up_en is still high.
  - A read and a write on the same address in the same cycle cannot occur, because writes are only accepted in FILL and reads only return data in READY.
- wr_cnt saturates at 16'hFFFF and does not wrap.

Decomposition:
- Shared package (cnn_pkg):
  - constants C1S2_OUT_DEPTH=1176, FMAP_DATA_W=16, ADDR_BUS_W=32.
  - buffer state encoding constants BUF_IDLE, BUF_FILL, BUF_READY.
- Sub-module s2_fmap_bank:
  - simple dual-port RAM, 1 write port / 1 read port, 1-cycle registered read, no reset on the array.
  - instantiated NPORT times in a generate loop.
- The top level holds the FSM, edge detectors, range checks, output gating and counters.

Test Plan:
- Normal fill/read:
  - Stimulus: up_en=1; write data 10000+i to addresses 0..1175; pulse up_fin; read port p at address 7p+3.
  - Response: wr_cnt=1176, buf_state=2, dn_en=1, err_flag=0, port p returns 10003+7p exactly 1 cycle later.
- Out-of-range and wrong-state writes:
  - Stimulus: in FILL, write address 1176 and address 32'hFFFF_FFFF; in IDLE, issue a write with wr_in_en=1.
  - Response: no store, wr_cnt unchanged, err_flag=1 and stays 1 until the next FILL entry.
- Read gating:
  - Stimulus: in FILL, read address 5; in READY, read address 2000.
  - Response: rd_data_out_5P=0 in both cases; a read of address 5 in READY returns the stored word.
- Handshake:
  - Stimulus: hold up_fin high for 50 cycles; then pulse dn_fin while up_en=1.
  - Response: a single FILL->READY transition; READY->IDLE, then FILL on the next cycle, with wr_cnt=0.
- Boundary write:
  - Stimulus: last write (address 1175, data 16'hABCD) in the same cycle as the up_fin rising edge.
  - Response: the write is accepted; reading address 1175 in READY returns 16'hABCD; wr_cnt=1176.
- Async reset mid-READY:
  - Stimulus: drop rst_n for 3 cycles, asynchronously to clk.
  - Response: dn_en=0, buf_state=0, outputs 0 immediately; after release, no transition until up_en=1.

Source files
------------

// File: rtl/cnn_pkg.sv
// Constants and buffer-state encoding shared by the CNN layer pipeline blocks.
package cnn_pkg;

  localparam int C1S2_OUT_DEPTH = 1176;
  localparam int FMAP_DATA_W    = 16;
  localparam int ADDR_BUS_W     = 32;

  typedef enum logic [1:0] {
    BUF_IDLE  = 2'd0,
    BUF_FILL  = 2'd1,
    BUF_READY = 2'd2
  } buf_state_e;

endpackage

// File: rtl/s2_fmap_bank.sv
// One feature-map storage copy: simple dual-port RAM with a registered read.
module s2_fmap_bank #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1176,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/s2_fmap_buffer.sv
// C1S2 -> C3S4 feature-map buffer: captures the producer's write stream, then
// serves the stored maps to the consumer through NPORT 1-cycle read ports.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   BUF_IDLE  | nobody owns the buffer; waiting for producer up_en
//   BUF_FILL  | producer owns it; in-range writes stored and counted
//   BUF_READY | consumer owns it; dn_en high, reads return stored words
module s2_fmap_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_W = FMAP_DATA_W,
  parameter int DEPTH  = C1S2_OUT_DEPTH,
  parameter int ADDR_W = 11,
  parameter int NPORT  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         up_en,
  input  logic                         up_fin,
  input  logic [ADDR_BUS_W-1:0]        wr_addr_in,
  input  logic [DATA_W-1:0]            wr_data_in,
  input  logic                         wr_in_en,
  input  logic [ADDR_BUS_W*NPORT-1:0]  rd_addr_in_5P,
  output logic [DATA_W*NPORT-1:0]      rd_data_out_5P,
  output logic                         dn_en,
  input  logic                         dn_fin,
  output logic [1:0]                   buf_state,
  output logic [15:0]                  wr_cnt,
  output logic                         err_flag
);

  buf_state_e        state_q, state_d;
  logic              up_fin_q, dn_fin_q;
  logic              up_fin_rise, dn_fin_rise;
  logic              fill_entry;
  logic              wr_in_range, wr_accept, wr_err;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic              err_q, err_d;
  logic              dn_en_q;
  logic [NPORT-1:0]  rd_ok_d, rd_ok_q;
  logic [DATA_W-1:0] bank_rdata [NPORT];

  assign up_fin_rise = up_fin & ~up_fin_q;
  assign dn_fin_rise = dn_fin & ~dn_fin_q;

  always_comb begin
    state_d    = state_q;
    fill_entry = 1'b0;
    case (state_q)
      BUF_IDLE: begin
        if (up_en) begin
          state_d    = BUF_FILL;
          fill_entry = 1'b1;
        end
      end
      BUF_FILL:  if (up_fin_rise) state_d = BUF_READY;
      BUF_READY: if (dn_fin_rise) state_d = BUF_IDLE;
      default:   state_d = BUF_IDLE;
    endcase
  end

  // Range check uses the full bus so aliased high addresses are rejected.
  assign wr_in_range = (wr_addr_in < ADDR_BUS_W'(DEPTH));
  assign wr_accept   = wr_in_en & wr_in_range & (state_q == BUF_FILL);
  assign wr_err      = wr_in_en & ~wr_accept;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    if (fill_entry) begin
      wr_cnt_d = '0;
      err_d    = 1'b0;
    end else begin
      if (wr_accept && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
      if (wr_err) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BUF_IDLE;
      up_fin_q <= 1'b0;
      dn_fin_q <= 1'b0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
      dn_en_q  <= 1'b0;
      rd_ok_q  <= '0;
    end else begin
      state_q  <= state_d;
      up_fin_q <= up_fin;
      dn_fin_q <= dn_fin;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
      dn_en_q  <= (state_d == BUF_READY);
      rd_ok_q  <= rd_ok_d;
    end
  end

  // Each port gets its own copy so all NPORT reads complete in one cycle.
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [ADDR_BUS_W-1:0] rd_addr;

    assign rd_addr    = rd_addr_in_5P[ADDR_BUS_W*p +: ADDR_BUS_W];
    assign rd_ok_d[p] = (state_q == BUF_READY) && (rd_addr < ADDR_BUS_W'(DEPTH));

    s2_fmap_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .we_i    (wr_accept),
      .waddr_i (wr_addr_in[ADDR_W-1:0]),
      .wdata_i (wr_data_in),
      .re_i    (rd_ok_d[p]),
      .raddr_i (rd_addr[ADDR_W-1:0]),
      .rdata_o (bank_rdata[p])
    );

    assign rd_data_out_5P[DATA_W*p +: DATA_W] = rd_ok_q[p] ? bank_rdata[p] : '0;
  end

  assign buf_state = state_q;
  assign dn_en     = dn_en_q;
  assign wr_cnt    = wr_cnt_q;
  assign err_flag  = err_q;

endmodule

// File: tb/tb_s2_fmap_buffer.sv
// Scenario bench for s2_fmap_buffer with a memory/ownership reference model.
module tb_s2_fmap_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 1176;
  localparam int NPORT  = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  up_en, up_fin, wr_in_en, dn_fin;
  logic [31:0]           wr_addr_in;
  logic [DATA_W-1:0]     wr_data_in;
  logic [32*NPORT-1:0]   rd_addr_in_5P;
  logic [DATA_W*NPORT-1:0] rd_data_out_5P;
  logic                  dn_en, err_flag;
  logic [1:0]            buf_state;
  logic [15:0]           wr_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] mem_model [DEPTH];
  int                exp_cnt;

  s2_fmap_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .up_en          (up_en),
    .up_fin         (up_fin),
    .wr_addr_in     (wr_addr_in),
    .wr_data_in     (wr_data_in),
    .wr_in_en       (wr_in_en),
    .rd_addr_in_5P  (rd_addr_in_5P),
    .rd_data_out_5P (rd_data_out_5P),
    .dn_en          (dn_en),
    .dn_fin         (dn_fin),
    .buf_state      (buf_state),
    .wr_cnt         (wr_cnt),
    .err_flag       (err_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference read: stored word only for an in-range address while READY.
  function automatic logic [DATA_W-1:0] ref_read(input bit ready, input logic [31:0] a);
    if (ready && a < DEPTH) return mem_model[a];
    return '0;
  endfunction

  task automatic set_rd(input int p, input logic [31:0] a);
    rd_addr_in_5P[32*p +: 32] = a;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [DATA_W-1:0] d, input bit in_fill);
    wr_addr_in = a;
    wr_data_in = d;
    wr_in_en   = 1'b1;
    tick();
    wr_in_en = 1'b0;
    if (in_fill && a < DEPTH) begin
      mem_model[a] = d;
      exp_cnt++;
    end
  endtask

  task automatic enter_fill();
    up_en = 1'b1;
    tick();
    up_en   = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic producer_done();
    up_fin = 1'b1;
    tick();
    up_fin = 1'b0;
  endtask

  task automatic consumer_done();
    dn_fin = 1'b1;
    tick();
    dn_fin = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    up_en = 0; up_fin = 0; wr_in_en = 0; dn_fin = 0;
    wr_addr_in = '0; wr_data_in = '0; rd_addr_in_5P = '0;
    tick(); tick();
    n_vec++;
    if (buf_state !== 2'd0 || dn_en !== 1'b0 || wr_cnt !== 16'd0 || err_flag !== 1'b0
        || rd_data_out_5P !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: state=%0d dn_en=%b cnt=%0d err=%b rd=%h, want all 0",
               buf_state, dn_en, wr_cnt, err_flag, rd_data_out_5P);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (buf_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_idle_hold: state=%0d want 0", buf_state);
    end
  endtask

  task automatic test_fill_read();
    logic [DATA_W-1:0] exp [NPORT];
    logic [31:0]       a;
    enter_fill();
    n_vec++;
    if (buf_state !== 2'd1 || wr_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL fill_entry: state=%0d cnt=%0d want 1/0", buf_state, wr_cnt);
    end
    for (int i = 0; i < DEPTH; i++) do_write(i, DATA_W'(10000 + i), 1'b1);
    n_vec++;
    if (wr_cnt !== 16'(exp_cnt) || exp_cnt != 1176) begin
      n_err++;
      $display("FAIL fill_count: cnt=%0d want 1176", wr_cnt);
    end
    producer_done();
    n_vec++;
    if (buf_state !== 2'd2 || dn_en !== 1'b1 || err_flag !== 1'b0) begin
      n_err++;
      $display("FAIL fill_ready: state=%0d dn_en=%b err=%b want 2/1/0", buf_state, dn_en, err_flag);
    end
    for (int p = 0; p < NPORT; p++) set_rd(p, 7*p + 3);
    tick();
    for (int p = 0; p < NPORT; p++) begin
      n_vec++;
      if (rd_data_out_5P[DATA_W*p +: DATA_W] !== DATA_W'(10003 + 7*p)) begin
        n_err++;
        $display("FAIL fill_read_p%0d: got %0d want %0d", p,
                 rd_data_out_5P[DATA_W*p +: DATA_W], 10003 + 7*p);
      end
    end
    for (int it = 0; it < 20; it++) begin
      for (int p = 0; p < NPORT; p++) begin
        a = $urandom_range(1300, 0);
        if ($urandom_range(9, 0) == 0) a = $urandom;
        set_rd(p, a);
        exp[p] = ref_read(1'b1, a);
      end
      tick();
      for (int p = 0; p < NPORT; p++) begin
        n_vec++;
        if (rd_data_out_5P[DATA_W*p +: DATA_W] !== exp[p]) begin
          n_err++;
          $display("FAIL rand_read_p%0d it%0d: got %h want %h", p, it,
                   rd_data_out_5P[DATA_W*p +: DATA_W], exp[p]);
        end
      end
    end
    consumer_done();
    n_vec++;
    if (buf_state !== 2'd0 || dn_en !== 1'b0) begin
      n_err++;
      $display("FAIL fill_release: state=%0d dn_en=%b want 0/0", buf_state, dn_en);
    end
  endtask

  task automatic test_bad_writes();
    logic [DATA_W-1:0] exp [NPORT];
    logic [31:0]       ra [NPORT];
    logic [31:0]       a;
    do_write(32'd3, 16'hDEAD, 1'b0);
    n_vec++;
    if (err_flag !== 1'b1 || buf_state !== 2'd0) begin
      n_err++;
      $display("FAIL idle_write_err: err=%b state=%0d want 1/0", err_flag, buf_state);
    end
    enter_fill();
    n_vec++;
    if (err_flag !== 1'b0 || wr_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL fill_clears_err: err=%b cnt=%0d want 0/0", err_flag, wr_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      a = $urandom_range(DEPTH-1, 10);
      do_write(a, DATA_W'($urandom), 1'b1);
    end
    do_write(32'd1176, 16'h1111, 1'b1);
    do_write(32'hFFFF_FFFF, 16'h2222, 1'b1);
    n_vec++;
    if (wr_cnt !== 16'(exp_cnt) || err_flag !== 1'b1) begin
      n_err++;
      $display("FAIL oor_write: cnt=%0d err=%b want %0d/1", wr_cnt, err_flag, exp_cnt);
    end
    do_write($urandom_range(DEPTH-1, 10), DATA_W'($urandom), 1'b1);
    producer_done();
    n_vec++;
    if (err_flag !== 1'b1 || wr_cnt !== 16'(exp_cnt) || buf_state !== 2'd2) begin
      n_err++;
      $display("FAIL err_sticky: err=%b cnt=%0d state=%0d want 1/%0d/2",
               err_flag, wr_cnt, buf_state, exp_cnt);
    end
    ra[0] = 32'd3; ra[1] = 32'd1176; ra[2] = 32'h7FF; ra[3] = 32'd1175; ra[4] = 32'd0;
    for (int p = 0; p < NPORT; p++) begin
      set_rd(p, ra[p]);
      exp[p] = ref_read(1'b1, ra[p]);
    end
    tick();
    for (int p = 0; p < NPORT; p++) begin
      n_vec++;
      if (rd_data_out_5P[DATA_W*p +: DATA_W] !== exp[p]) begin
        n_err++;
        $display("FAIL bad_write_read_p%0d: got %h want %h", p,
                 rd_data_out_5P[DATA_W*p +: DATA_W], exp[p]);
      end
    end
    consumer_done();
    n_vec++;
    if (err_flag !== 1'b1) begin
      n_err++;
      $display("FAIL err_after_ready: err=%b want 1", err_flag);
    end
  endtask

  task automatic test_read_gating();
    logic [DATA_W-1:0] exp [NPORT];
    logic [DATA_W-1:0] d;
    enter_fill();
    for (int p = 0; p < NPORT; p++) set_rd(p, 32'd5);
    d = DATA_W'($urandom);
    do_write(32'd5, d, 1'b1);
    n_vec++;
    if (rd_data_out_5P !== '0) begin
      n_err++;
      $display("FAIL gate_fill: rd=%h want 0", rd_data_out_5P);
    end
    producer_done();
    for (int p = 0; p < NPORT; p++) set_rd(p, 32'd2000);
    tick();
    n_vec++;
    if (rd_data_out_5P !== '0) begin
      n_err++;
      $display("FAIL gate_oor: rd=%h want 0", rd_data_out_5P);
    end
    for (int p = 0; p < NPORT; p++) begin
      set_rd(p, (p % 2 == 0) ? 32'd5 : 32'd2000);
      exp[p] = ref_read(1'b1, (p % 2 == 0) ? 32'd5 : 32'd2000);
    end
    tick();
    for (int p = 0; p < NPORT; p++) begin
      n_vec++;
      if (rd_data_out_5P[DATA_W*p +: DATA_W] !== exp[p]) begin
        n_err++;
        $display("FAIL gate_ready_p%0d: got %h want %h", p,
                 rd_data_out_5P[DATA_W*p +: DATA_W], exp[p]);
      end
    end
    consumer_done();
  endtask

  task automatic test_handshake();
    int n_trans;
    logic [1:0] prev;
    enter_fill();
    for (int i = 0; i < 3; i++) do_write($urandom_range(DEPTH-1, 0), DATA_W'($urandom), 1'b1);
    up_fin  = 1'b1;
    up_en   = 1'b1;
    n_trans = 0;
    prev    = buf_state;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (prev == 2'd1 && buf_state == 2'd2) n_trans++;
      prev = buf_state;
    end
    n_vec++;
    if (n_trans != 1 || buf_state !== 2'd2 || dn_en !== 1'b1 || wr_cnt !== 16'(exp_cnt)) begin
      n_err++;
      $display("FAIL hs_single_ready: trans=%0d state=%0d dn_en=%b cnt=%0d want 1/2/1/%0d",
               n_trans, buf_state, dn_en, wr_cnt, exp_cnt);
    end
    dn_fin = 1'b1;
    tick();
    dn_fin = 1'b0;
    n_vec++;
    if (buf_state !== 2'd0 || dn_en !== 1'b0) begin
      n_err++;
      $display("FAIL hs_release: state=%0d dn_en=%b want 0/0", buf_state, dn_en);
    end
    tick();
    n_vec++;
    if (buf_state !== 2'd1 || wr_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL hs_refill: state=%0d cnt=%0d want 1/0", buf_state, wr_cnt);
    end
    up_en   = 1'b0;
    exp_cnt = 0;
    tick();
    n_vec++;
    if (buf_state !== 2'd1) begin
      n_err++;
      $display("FAIL hs_no_stale_fin: state=%0d want 1", buf_state);
    end
    up_fin = 1'b0;
    tick();
  endtask

  task automatic test_boundary();
    logic [DATA_W-1:0] exp [NPORT];
    logic [31:0]       a;
    for (int i = 0; i < DEPTH-1; i++) do_write(i, DATA_W'($urandom), 1'b1);
    up_fin = 1'b1;
    do_write(32'd1175, 16'hABCD, 1'b1);
    up_fin = 1'b0;
    n_vec++;
    if (buf_state !== 2'd2 || wr_cnt !== 16'd1176 || exp_cnt != 1176) begin
      n_err++;
      $display("FAIL boundary_state: state=%0d cnt=%0d want 2/1176", buf_state, wr_cnt);
    end
    set_rd(0, 32'd1175);
    exp[0] = 16'hABCD;
    for (int p = 1; p < NPORT; p++) begin
      a = $urandom_range(DEPTH-1, 0);
      set_rd(p, a);
      exp[p] = ref_read(1'b1, a);
    end
    tick();
    for (int p = 0; p < NPORT; p++) begin
      n_vec++;
      if (rd_data_out_5P[DATA_W*p +: DATA_W] !== exp[p]) begin
        n_err++;
        $display("FAIL boundary_read_p%0d: got %h want %h", p,
                 rd_data_out_5P[DATA_W*p +: DATA_W], exp[p]);
      end
    end
  endtask

  task automatic test_async_reset();
    n_vec++;
    if (rd_data_out_5P[DATA_W-1:0] !== 16'hABCD || buf_state !== 2'd2) begin
      n_err++;
      $display("FAIL pre_reset: rd0=%h state=%0d want abcd/2", rd_data_out_5P[DATA_W-1:0], buf_state);
    end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if (buf_state !== 2'd0 || dn_en !== 1'b0 || rd_data_out_5P !== '0 || wr_cnt !== 16'd0
        || err_flag !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: state=%0d dn_en=%b rd=%h cnt=%0d err=%b want all 0",
               buf_state, dn_en, rd_data_out_5P, wr_cnt, err_flag);
    end
    #30 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (buf_state !== 2'd0 || rd_data_out_5P !== '0) begin
        n_err++;
        $display("FAIL post_reset_idle%0d: state=%0d rd=%h want 0/0", i, buf_state, rd_data_out_5P);
      end
    end
    enter_fill();
    n_vec++;
    if (buf_state !== 2'd1) begin
      n_err++;
      $display("FAIL post_reset_fill: state=%0d want 1", buf_state);
    end
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_bad_writes();
    test_read_gating();
    test_handshake();
    test_boundary();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
